// File: rtl/md_pkg.sv
// Shared constants and types for the mul/div sequencer and the control decoder.
package md_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } md_state_t;

   localparam logic [4:0] OP_RTYPE = 5'b00000;
   localparam logic [4:0] FN_MUL   = 5'b00110;
   localparam logic [4:0] FN_DIV   = 5'b00111;

   localparam int RSTATUS_IDX  = 30;
   localparam int MUL_EXC      = 4;
   localparam int DIV_EXC      = 5;

   function automatic logic is_md_op(input logic [4:0] opcode, input logic [4:0] func);
      return (opcode == OP_RTYPE) && ((func == FN_MUL) || (func == FN_DIV));
   endfunction

endpackage

// File: rtl/md_watchdog.sv
// Busy-cycle watchdog for the mul/div sequencer; only exists when MD_TIMEOUT_EN is defined.
`ifdef MD_TIMEOUT_EN
module md_watchdog #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic clock,
   input  logic reset_n,
   input  logic start,
   input  logic busy,
   output logic expired
);

   logic [7:0] cnt;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= 8'd0;
      end else if (start) begin
         cnt <= 8'd0;
      end else if (busy && (cnt != 8'hff)) begin
         cnt <= cnt + 8'd1;
      end
   end

   // cnt holds (busy cycles elapsed - 1), so this fires on the last allowed BUSY cycle
   assign expired = busy && (cnt == 8'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/md_sequencer.sv
// Launches mul/div ops into the shared multdiv unit, stalls the pipe, and issues one writeback.
// Optional BUSY watchdog enabled by defining MD_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for a mul/div in X; stalls combinationally on acceptance
// BUSY  | multdiv running; start pulse on first cycle, waits for md_ready
// DONE  | one-cycle writeback to rd (or rstatus on exception)
module md_sequencer
   import md_pkg::*;
#(
   parameter int DATA_W         = 32,
   parameter int RSTATUS_REG    = RSTATUS_IDX,
   parameter int MUL_EXC_CODE   = MUL_EXC,
   parameter int DIV_EXC_CODE   = DIV_EXC,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              issue_valid,
   input  logic [4:0]        opcode,
   input  logic [4:0]        Func,
   input  logic [4:0]        rd,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   input  logic              flush,
   input  logic              md_ready,
   input  logic              md_exception,
   input  logic [DATA_W-1:0] md_result,
   output logic              md_ctrl_mult,
   output logic              md_ctrl_div,
   output logic [DATA_W-1:0] md_a,
   output logic [DATA_W-1:0] md_b,
   output logic              stall,
   output logic              wb_valid,
   output logic [4:0]        wb_rd,
   output logic [DATA_W-1:0] wb_data
);

   md_state_t         state;
   logic              is_div_q;
   logic [4:0]        rd_q;
   logic              wb_pend_q;
   logic              accept;
   logic              start_q;
   logic              take_ready;
   logic              timeout;
   logic              fin;
   logic              fin_exc;
   logic [DATA_W-1:0] exc_code;

   assign accept     = (state == IDLE) && issue_valid && is_md_op(opcode, Func) && !flush;
   // The start pulse marks the first BUSY cycle, where md_ready is stale from the last op
   assign start_q    = md_ctrl_mult || md_ctrl_div;
   assign take_ready = !start_q && md_ready;
   assign fin        = take_ready || timeout;
   assign fin_exc    = take_ready ? md_exception : 1'b1;
   assign exc_code   = is_div_q ? DATA_W'(DIV_EXC_CODE) : DATA_W'(MUL_EXC_CODE);

   assign stall    = accept || (state == BUSY);
   assign wb_valid = (state == DONE) && wb_pend_q && !flush;

`ifdef MD_TIMEOUT_EN
   md_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clock   (clock),
      .reset_n (reset_n),
      .start   (accept),
      .busy    (state == BUSY),
      .expired (timeout)
   );
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign timeout            = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         is_div_q     <= 1'b0;
         rd_q         <= 5'd0;
         wb_pend_q    <= 1'b0;
         md_ctrl_mult <= 1'b0;
         md_ctrl_div  <= 1'b0;
         md_a         <= '0;
         md_b         <= '0;
         wb_rd        <= 5'd0;
         wb_data      <= '0;
      end else begin
         md_ctrl_mult <= 1'b0;
         md_ctrl_div  <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  state        <= BUSY;
                  is_div_q     <= (Func == FN_DIV);
                  rd_q         <= rd;
                  md_a         <= op_a;
                  md_b         <= op_b;
                  md_ctrl_mult <= (Func == FN_MUL);
                  md_ctrl_div  <= (Func == FN_DIV);
               end
            end
            BUSY: begin
               if (flush) begin
                  state <= IDLE;
               end else if (fin) begin
                  state     <= DONE;
                  wb_pend_q <= fin_exc || (rd_q != 5'd0);
                  wb_rd     <= fin_exc ? 5'(RSTATUS_REG) : rd_q;
                  wb_data   <= fin_exc ? exc_code : md_result;
               end
            end
            DONE: begin
               state     <= IDLE;
               wb_pend_q <= 1'b0;
               wb_rd     <= 5'd0;
               wb_data   <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_md_sequencer.sv
// Directed self-checking bench for md_sequencer; inputs change just after the rising edge,
// outputs are checked on the falling edge.
module tb_md_sequencer;
   import md_pkg::*;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        issue_valid;
   logic [4:0]  opcode;
   logic [4:0]  Func;
   logic [4:0]  rd;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        flush;
   logic        md_ready;
   logic        md_exception;
   logic [31:0] md_result;
   logic        md_ctrl_mult;
   logic        md_ctrl_div;
   logic [31:0] md_a;
   logic [31:0] md_b;
   logic        stall;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   md_sequencer #(
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .issue_valid  (issue_valid),
      .opcode       (opcode),
      .Func         (Func),
      .rd           (rd),
      .op_a         (op_a),
      .op_b         (op_b),
      .flush        (flush),
      .md_ready     (md_ready),
      .md_exception (md_exception),
      .md_result    (md_result),
      .md_ctrl_mult (md_ctrl_mult),
      .md_ctrl_div  (md_ctrl_div),
      .md_a         (md_a),
      .md_b         (md_b),
      .stall        (stall),
      .wb_valid     (wb_valid),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic mid();
      @(negedge clock);
   endtask

   task automatic issue(input logic [4:0] fn, input logic [4:0] r, input logic [31:0] a,
                        input logic [31:0] b);
      issue_valid = 1'b1;
      opcode      = OP_RTYPE;
      Func        = fn;
      rd          = r;
      op_a        = a;
      op_b        = b;
   endtask

   initial begin
      reset_n = 1'b0; issue_valid = 1'b0; opcode = 5'd0; Func = 5'd0; rd = 5'd0;
      op_a = 32'd0; op_b = 32'd0; flush = 1'b0; md_ready = 1'b0; md_exception = 1'b0;
      md_result = 32'd0;

      // reset state
      mid();
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_mult", {31'd0, md_ctrl_mult}, 32'd0);
      chk("rst_wbv", {31'd0, wb_valid}, 32'd0);
      chk("rst_wbdata", wb_data, 32'd0);
      chk("rst_mda", md_a, 32'd0);
      cyc(); reset_n = 1'b1;

      // mul rd=5 6*7, ready four cycles after the start pulse
      cyc(); issue(FN_MUL, 5'd5, 32'd6, 32'd7); mid();
      chk("t1_acc_stall", {31'd0, stall}, 32'd1);
      chk("t1_acc_mult", {31'd0, md_ctrl_mult}, 32'd0);
      cyc(); issue_valid = 1'b0; mid();
      chk("t1_start_mult", {31'd0, md_ctrl_mult}, 32'd1);
      chk("t1_start_div", {31'd0, md_ctrl_div}, 32'd0);
      chk("t1_start_stall", {31'd0, stall}, 32'd1);
      chk("t1_mda", md_a, 32'd6);
      chk("t1_mdb", md_b, 32'd7);
      for (int i = 2; i <= 4; i++) begin
         cyc(); mid();
         chk("t1_busy_stall", {31'd0, stall}, 32'd1);
         chk("t1_busy_mult", {31'd0, md_ctrl_mult}, 32'd0);
         chk("t1_busy_mda", md_a, 32'd6);
      end
      cyc(); md_ready = 1'b1; md_result = 32'd42; mid();
      chk("t1_rdy_stall", {31'd0, stall}, 32'd1);
      chk("t1_rdy_wbv", {31'd0, wb_valid}, 32'd0);
      cyc(); md_ready = 1'b0; mid();
      chk("t1_wbv", {31'd0, wb_valid}, 32'd1);
      chk("t1_wbrd", {27'd0, wb_rd}, 32'd5);
      chk("t1_wbdata", wb_data, 32'd42);
      chk("t1_done_stall", {31'd0, stall}, 32'd0);
      cyc(); mid();
      chk("t1_after_wbv", {31'd0, wb_valid}, 32'd0);

      // div by zero with exception; a new mul offered during DONE waits one cycle
      cyc(); issue(FN_DIV, 5'd3, 32'd9, 32'd0); mid();
      chk("t2_acc_stall", {31'd0, stall}, 32'd1);
      cyc(); issue_valid = 1'b0; mid();
      chk("t2_start_div", {31'd0, md_ctrl_div}, 32'd1);
      chk("t2_start_mult", {31'd0, md_ctrl_mult}, 32'd0);
      cyc(); md_ready = 1'b1; md_exception = 1'b1; md_result = 32'hdead; mid();
      cyc(); md_ready = 1'b0; md_exception = 1'b0; issue(FN_MUL, 5'd9, 32'd2, 32'd3); mid();
      chk("t2_wbv", {31'd0, wb_valid}, 32'd1);
      chk("t2_wbrd", {27'd0, wb_rd}, 32'd30);
      chk("t2_wbdata", wb_data, 32'd5);
      chk("t2_done_stall", {31'd0, stall}, 32'd0);
      cyc(); mid();
      chk("t2_next_stall", {31'd0, stall}, 32'd1);
      chk("t2_next_mult", {31'd0, md_ctrl_mult}, 32'd0);
      chk("t2_next_wbv", {31'd0, wb_valid}, 32'd0);
      cyc(); issue_valid = 1'b0; mid();
      chk("t2b_start_mult", {31'd0, md_ctrl_mult}, 32'd1);
      chk("t2b_mda", md_a, 32'd2);
      chk("t2b_mdb", md_b, 32'd3);
      cyc(); md_ready = 1'b1; md_result = 32'd6; mid();
      cyc(); md_ready = 1'b0; mid();
      chk("t2b_wbv", {31'd0, wb_valid}, 32'd1);
      chk("t2b_wbrd", {27'd0, wb_rd}, 32'd9);
      chk("t2b_wbdata", wb_data, 32'd6);

      // md_ready already high on the start-pulse cycle
      cyc(); issue(FN_MUL, 5'd7, 32'd3, 32'd5); mid();
      cyc(); issue_valid = 1'b0; md_ready = 1'b1; md_result = 32'd15; mid();
      chk("t3_start_mult", {31'd0, md_ctrl_mult}, 32'd1);
      chk("t3_start_wbv", {31'd0, wb_valid}, 32'd0);
      cyc(); mid();
      chk("t3_take_stall", {31'd0, stall}, 32'd1);
      chk("t3_take_wbv", {31'd0, wb_valid}, 32'd0);
      cyc(); md_ready = 1'b0; mid();
      chk("t3_wbv", {31'd0, wb_valid}, 32'd1);
      chk("t3_wbrd", {27'd0, wb_rd}, 32'd7);
      chk("t3_wbdata", wb_data, 32'd15);

      // flush two cycles after the start pulse, later md_ready is ignored
      cyc(); issue(FN_MUL, 5'd4, 32'd1, 32'd1); mid();
      cyc(); issue_valid = 1'b0; mid();
      cyc(); mid();
      cyc(); flush = 1'b1; mid();
      chk("t4_flush_stall", {31'd0, stall}, 32'd1);
      cyc(); flush = 1'b0; mid();
      chk("t4_idle_stall", {31'd0, stall}, 32'd0);
      chk("t4_idle_wbv", {31'd0, wb_valid}, 32'd0);
      cyc(); md_ready = 1'b1; md_result = 32'd1; mid();
      chk("t4_late_wbv", {31'd0, wb_valid}, 32'd0);
      cyc(); md_ready = 1'b0; mid();
      chk("t4_late_wbv2", {31'd0, wb_valid}, 32'd0);
      chk("t4_late_stall", {31'd0, stall}, 32'd0);

      // flush together with md_ready: flush wins
      cyc(); issue(FN_DIV, 5'd2, 32'd8, 32'd2); mid();
      cyc(); issue_valid = 1'b0; mid();
      cyc(); md_ready = 1'b1; md_result = 32'd4; flush = 1'b1; mid();
      cyc(); md_ready = 1'b0; flush = 1'b0; mid();
      chk("t5_wbv", {31'd0, wb_valid}, 32'd0);
      chk("t5_stall", {31'd0, stall}, 32'd0);

      // flush during DONE suppresses the write
      cyc(); issue(FN_MUL, 5'd6, 32'd1, 32'd2); mid();
      cyc(); issue_valid = 1'b0; mid();
      cyc(); md_ready = 1'b1; md_result = 32'd2; mid();
      cyc(); md_ready = 1'b0; flush = 1'b1; mid();
      chk("t6_done_flush_wbv", {31'd0, wb_valid}, 32'd0);
      cyc(); flush = 1'b0; mid();
      chk("t6_idle_stall", {31'd0, stall}, 32'd0);

      // rd=0: no write without exception, rstatus write with overflow
      cyc(); issue(FN_MUL, 5'd0, 32'd2, 32'd2); mid();
      cyc(); issue_valid = 1'b0; mid();
      cyc(); md_ready = 1'b1; md_result = 32'd4; mid();
      cyc(); md_ready = 1'b0; mid();
      chk("t7_rd0_wbv", {31'd0, wb_valid}, 32'd0);
      chk("t7_rd0_stall", {31'd0, stall}, 32'd0);
      cyc(); issue(FN_MUL, 5'd0, 32'h8000_0000, 32'd4); mid();
      cyc(); issue_valid = 1'b0; mid();
      cyc(); md_ready = 1'b1; md_exception = 1'b1; md_result = 32'd0; mid();
      cyc(); md_ready = 1'b0; md_exception = 1'b0; mid();
      chk("t7_ovf_wbv", {31'd0, wb_valid}, 32'd1);
      chk("t7_ovf_wbrd", {27'd0, wb_rd}, 32'd30);
      chk("t7_ovf_wbdata", wb_data, 32'd4);

      // not accepted: flushed in IDLE, non-md func, non-R opcode, invalid
      cyc(); issue(FN_MUL, 5'd5, 32'd1, 32'd1); flush = 1'b1; mid();
      chk("t8_flush_stall", {31'd0, stall}, 32'd0);
      cyc(); flush = 1'b0; issue(5'b00001, 5'd5, 32'd1, 32'd1); mid();
      chk("t8_flush_mult", {31'd0, md_ctrl_mult}, 32'd0);
      chk("t8_alu_stall", {31'd0, stall}, 32'd0);
      cyc(); issue(FN_DIV, 5'd5, 32'd1, 32'd1); opcode = 5'b00101; mid();
      chk("t8_alu_div", {31'd0, md_ctrl_div}, 32'd0);
      chk("t8_opc_stall", {31'd0, stall}, 32'd0);
      cyc(); issue(FN_MUL, 5'd5, 32'd1, 32'd1); issue_valid = 1'b0; mid();
      chk("t8_opc_div", {31'd0, md_ctrl_div}, 32'd0);
      chk("t8_inv_stall", {31'd0, stall}, 32'd0);
      cyc(); mid();
      chk("t8_inv_mult", {31'd0, md_ctrl_mult}, 32'd0);

      // md_ready never arrives
      cyc(); issue(FN_MUL, 5'd5, 32'd1, 32'd1); mid();
      cyc(); issue_valid = 1'b0; mid();
      repeat (6) cyc();
      cyc(); mid();
      chk("t9_busy8_stall", {31'd0, stall}, 32'd1);
      chk("t9_busy8_wbv", {31'd0, wb_valid}, 32'd0);
      cyc(); mid();
`ifdef MD_TIMEOUT_EN
      chk("t9_to_wbv", {31'd0, wb_valid}, 32'd1);
      chk("t9_to_wbrd", {27'd0, wb_rd}, 32'd30);
      chk("t9_to_wbdata", wb_data, 32'd4);
      chk("t9_to_stall", {31'd0, stall}, 32'd0);
`else
      chk("t9_hang_stall", {31'd0, stall}, 32'd1);
      chk("t9_hang_wbv", {31'd0, wb_valid}, 32'd0);
      repeat (10) cyc();
      mid();
      chk("t9_hang_stall2", {31'd0, stall}, 32'd1);
`endif
      reset_n = 1'b0;
      #1;
      chk("t9_rst_stall", {31'd0, stall}, 32'd0);
      cyc(); reset_n = 1'b1;

      // reset mid-op abandons it; later md_ready is ignored
      cyc(); issue(FN_DIV, 5'd8, 32'd10, 32'd2); mid();
      cyc(); issue_valid = 1'b0; mid();
      chk("t10_start_div", {31'd0, md_ctrl_div}, 32'd1);
      cyc(); reset_n = 1'b0; mid();
      chk("t10_rst_stall", {31'd0, stall}, 32'd0);
      chk("t10_rst_mdb", md_b, 32'd0);
      cyc(); reset_n = 1'b1; md_ready = 1'b1; md_result = 32'd5; mid();
      chk("t10_rdy_wbv", {31'd0, wb_valid}, 32'd0);
      cyc(); md_ready = 1'b0; mid();
      chk("t10_after_wbv", {31'd0, wb_valid}, 32'd0);
      chk("t10_after_stall", {31'd0, stall}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
- Sequences the shared multicycle multiply/divide unit for the 5-bit-opcode processor.
- Sits beside the execute stage and decodes mul/div (R-type, opcode 00000, Func 00110 = mul, Func 00111 = div).
- Launches the op into the multdiv unit, stalls the pipeline while the unit works, then produces one writeback.
- On a multdiv exception, the writeback goes to rstatus (r30) with the exception code instead of rd.

Parameters:
- DATA_W, 32, operand/result width
- RSTATUS_REG, 30, register index written on exception
- MUL_EXC_CODE, 4, rstatus value for mul overflow
- DIV_EXC_CODE, 5, rstatus value for div-by-zero
- TIMEOUT_CYCLES, 64, watchdog limit (optional feature only)

Ports:
- clock  in  1  single clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- issue_valid  in  1  X-stage instruction valid
- opcode  in  5  X-stage opcode
- Func  in  5  X-stage ALU function field
- rd  in  5  X-stage destination register
- op_a, op_b  in  DATA_W  X-stage operands
- flush  in  1  squash from taken branch/jump
- md_ready  in  1  multdiv result valid
- md_exception  in  1  multdiv overflow / div-by-zero
- md_result  in  DATA_W  multdiv result
- md_ctrl_mult  out  1  one-cycle start pulse, multiply
- md_ctrl_div  out  1  one-cycle start pulse, divide
- md_a, md_b  out  DATA_W  latched operands to multdiv
- stall  out  1  freeze F/D/X pipeline registers
- wb_valid  out  1  one-cycle register-file write request
- wb_rd  out  5  write address
- wb_data  out  DATA_W  write data

Behaviour:
- Reset (async, reset_n low): state=IDLE; all outputs 0; latches cleared. Reset mid-op abandons it; no writeback. A later md_ready is ignored.
- is_md = issue_valid & opcode==00000 & Func in {00110, 00111}.
- IDLE:
  - stall = is_md & ~flush (combinational).
  - On is_md & ~flush: latch op kind, rd, op_a -> md_a, op_b -> md_b; next state BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - First BUSY cycle: md_ctrl_mult or md_ctrl_div = 1 (registered, exactly one cycle). md_ready is ignored in this cycle.
  - md_a/md_b stay stable for the whole of BUSY. stall = 1.
  - From the second BUSY cycle: on md_ready, latch md_result and md_exception; next state DONE.
- DONE (one cycle):
  - stall = 0, so the pipeline advances past the mul/div this cycle.
  - wb_valid = 1, except wb_valid = 0 when rd==0 and no exception.
  - No exception: wb_rd = latched rd, wb_data = latched result.
  - Exception: wb_rd = RSTATUS_REG, wb_data = MUL_EXC_CODE or DIV_EXC_CODE, zero-extended to DATA_W.
  - Next state IDLE. A new mul/div in X during DONE is not accepted; it is taken in the following IDLE cycle.
- Flush:
  - In IDLE: suppresses acceptance.
  - In BUSY: next state IDLE, stall drops next cycle, no writeback.
  - In DONE: forces wb_valid = 0.
  - flush together with md_ready: flush wins.
- Latency: accept at cycle N, start pulse at N+1, md_ready earliest at N+2, wb_valid at ready+1.
- Non-md instructions never touch md_* outputs.

Optional Feature:
- Macro MD_TIMEOUT_EN.
- Defined:
  - 8-bit counter cleared on entering BUSY, increments each BUSY cycle.
  - If it reaches TIMEOUT_CYCLES without md_ready: go to DONE with exception forced, writing the op's exception code to rstatus.
  - md_ready in the same cycle as the timeout takes priority (normal result).
- Undefined: no counter; BUSY waits indefinitely for md_ready.

Decomposition:
- Shared package md_pkg:
  - state enum (IDLE, BUSY, DONE)
  - opcode/Func constants (OP_RTYPE = 00000, FN_MUL = 00110, FN_DIV = 00111)
  - RSTATUS index and exception-code constants
- Constants are shared with the control decoder.
- One natural sub-module, md_watchdog: the timeout counter, instantiated only under MD_TIMEOUT_EN.

Test Plan:
- mul, rd=5, a=6, b=7, md_ready 4 cycles after start:
  - start pulse at N+1 only; stall high N through N+5.
  - wb_valid=1, wb_rd=5, wb_data=42 at N+6; stall=0 that cycle.
- div, rd=3, b=0, md_exception=1 with ready: wb_rd=30, wb_data=5; no write to r3.
- mul in BUSY, flush asserted 2 cycles after start: state IDLE, stall low next cycle; a later md_ready produces no wb_valid.
- md_ready held high on the start-pulse cycle: ignored; result taken the next cycle.
- mul with rd=0, no exception: wb_valid=0. Same op with overflow: wb_rd=30, wb_data=4.
- MD_TIMEOUT_EN, TIMEOUT_CYCLES=8, md_ready never asserted: DONE after 8 BUSY cycles, wb_rd=30, wb_data=4 (mul); without the macro, stall stays high.
